// File: rtl/mem_access_pkg.sv
// mem_access_pkg: FSM state and memory op encodings shared with the multicycle controller
package mem_access_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_DONE} state_e;
  typedef enum logic [1:0] {OP_FETCH, OP_LOAD, OP_STORE, OP_RSVD} op_e;
  function automatic op_e norm_op(op_e op);
    return op == OP_RSVD ? OP_LOAD : op;
  endfunction
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: controller request/response plus memory bus bundle
//   master: requester side (drives req_*, pc, alu_addr, store_data, abort, Mem_data)
//   slave:  mem_access_ctrl side (drives req_ready, done, err, ir, mdr, Address, Write_data, MemRead, MemWrite)
interface mem_access_ctrl_if;
  import mem_access_pkg::*;
  logic        req_valid;
  logic        req_ready;
  op_e         req_op;
  logic [31:0] pc;
  logic [31:0] alu_addr;
  logic [31:0] store_data;
  logic        abort;
  logic        done;
  logic        err;
  logic [31:0] ir;
  logic [31:0] mdr;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Mem_data;
  modport master (
    output req_valid, req_op, pc, alu_addr, store_data, abort, Mem_data,
    input  req_ready, done, err, ir, mdr, Address, Write_data, MemRead, MemWrite
  );
  modport slave (
    input  req_valid, req_op, pc, alu_addr, store_data, abort, Mem_data,
    output req_ready, done, err, ir, mdr, Address, Write_data, MemRead, MemWrite
  );
endinterface

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: loadable down-counter with zero flag for wait states
//   clk, reset: clock, sync active-high reset; load/load_val: preset; dec: decrement; zero: count==0
module mem_wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : dec ? cnt_q - CNT_W'(1) : cnt_q;
  always_ff @(posedge clk)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: one-at-a-time fetch/load/store sequencer to unified memory with wait states
//   clk, reset: clock, sync active-high reset; bus: mem_access_ctrl_if.slave (request + memory side)
//   MEM_MISALIGN_TRAP_EN: when defined, misaligned requests skip the access and return done+err
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int CNT_W       = 4
) (
  input logic              clk,
  input logic              reset,
  mem_access_ctrl_if.slave bus
);
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ir_q, ir_d, mdr_q, mdr_d, sel_addr;
  logic        err_q, err_d, cnt_load, cnt_dec, cnt_zero;
  mem_wait_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );
  assign sel_addr = bus.req_op == OP_FETCH ? bus.pc : bus.alu_addr;
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ir_d     = ir_q;
    mdr_d    = mdr_q;
    err_d    = err_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.req_valid) begin
        op_d     = norm_op(bus.req_op);
        addr_d   = sel_addr;
        wdata_d  = bus.store_data;
        err_d    = TRAP_EN && sel_addr[1:0] != 2'b00;
        cnt_load = 1'b1;
        state_d  = err_d ? ST_DONE : WAIT_CYCLES > 0 ? ST_WAIT : ST_ACCESS;
      end
      ST_WAIT: begin
        state_d = bus.abort ? ST_IDLE : cnt_zero ? ST_ACCESS : ST_WAIT;
        cnt_dec = !bus.abort && !cnt_zero;
      end
      ST_ACCESS: begin
        ir_d    = op_q == OP_FETCH ? bus.Mem_data : ir_q;
        mdr_d   = op_q == OP_LOAD ? bus.Mem_data : mdr_q;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_FETCH;
      addr_q  <= '0;
      wdata_q <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      err_q   <= err_d;
    end
  // Strobes are masked while reset is high so a reset landing in ACCESS never commits a write.
  assign bus.MemRead    = !reset && state_q == ST_ACCESS && op_q != OP_STORE;
  assign bus.MemWrite   = !reset && state_q == ST_ACCESS && op_q == OP_STORE;
  assign bus.req_ready  = state_q == ST_IDLE;
  assign bus.done       = state_q == ST_DONE;
  assign bus.err        = TRAP_EN && state_q == ST_DONE && err_q;
  assign bus.ir         = ir_q;
  assign bus.mdr        = mdr_q;
  assign bus.Address    = addr_q;
  assign bus.Write_data = wdata_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed bench for mem_access_ctrl with WAIT_CYCLES=0 and WAIT_CYCLES=3 instances
module tb_mem_access_ctrl;
  import mem_access_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [31:0] mem0 [256];
  logic [31:0] mem3 [256];
  logic        bd_we0 = 1'b0, bd_we3 = 1'b0;
  logic [7:0]  bd_a = '0;
  logic [31:0] bd_d = '0;
  mem_access_ctrl_if if0 ();
  mem_access_ctrl_if if3 ();
  mem_access_ctrl #(.WAIT_CYCLES(0), .CNT_W(4)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  mem_access_ctrl #(.WAIT_CYCLES(3), .CNT_W(4)) dut3 (.clk(clk), .reset(reset), .bus(if3.slave));
  always #5 clk = ~clk;
  assign if0.Mem_data = mem0[if0.Address[9:2]];
  assign if3.Mem_data = mem3[if3.Address[9:2]];
  always @(posedge clk) begin
    if (bd_we0) mem0[bd_a] <= bd_d;
    else if (if0.MemWrite) mem0[if0.Address[9:2]] <= if0.Write_data;
    if (bd_we3) mem3[bd_a] <= bd_d;
    else if (if3.MemWrite) mem3[if3.Address[9:2]] <= if3.Write_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bd(input bit w3, input logic [7:0] a, input logic [31:0] d);
    bd_we0 = !w3;
    bd_we3 = w3;
    bd_a   = a;
    bd_d   = d;
    step();
    bd_we0 = 1'b0;
    bd_we3 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    tests++; if (if0.req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", if0.req_ready); end
    tests++; if (if0.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", if0.done); end
    tests++; if (if0.err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", if0.err); end
    tests++; if (if0.ir !== 32'h0) begin fails++; $display("FAIL reset_ir: got %h want 0", if0.ir); end
    tests++; if (if0.mdr !== 32'h0) begin fails++; $display("FAIL reset_mdr: got %h want 0", if0.mdr); end
    tests++; if (if0.Address !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", if0.Address); end
    tests++; if ({if0.MemRead, if0.MemWrite} !== 2'b00) begin fails++; $display("FAIL reset_strobes: got %b want 00", {if0.MemRead, if0.MemWrite}); end
    tests++; if (if3.req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready3: got %b want 1", if3.req_ready); end
  endtask

  task automatic test_fetch();
    bd(1'b0, 8'h00, 32'h20040005);
    bd(1'b0, 8'h10, 32'h11111111);
    if0.req_op    = OP_FETCH;
    if0.pc        = 32'h0;
    if0.alu_addr  = 32'h40;
    if0.req_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) step();
      if (c == 1) if0.req_valid = 1'b0;
      tests++; if (if0.MemRead !== (c == 1)) begin fails++; $display("FAIL fetch_memread c%0d: got %b want %b", c, if0.MemRead, c == 1); end
      tests++; if (if0.done !== (c == 2)) begin fails++; $display("FAIL fetch_done c%0d: got %b want %b", c, if0.done, c == 2); end
      tests++; if (if0.MemWrite !== 1'b0) begin fails++; $display("FAIL fetch_memwrite c%0d: got %b want 0", c, if0.MemWrite); end
    end
    tests++; if (if0.ir !== 32'h20040005) begin fails++; $display("FAIL fetch_ir: got %h want 20040005", if0.ir); end
    tests++; if (if0.mdr !== 32'h0) begin fails++; $display("FAIL fetch_mdr: got %h want 0", if0.mdr); end
    tests++; if (if0.Address !== 32'h0) begin fails++; $display("FAIL fetch_addr_hold: got %h want 0", if0.Address); end
  endtask

  task automatic test_store_load();
    if3.req_op     = OP_STORE;
    if3.pc         = 32'h0;
    if3.alu_addr   = 32'h80;
    if3.store_data = 32'hDEADBEEF;
    if3.req_valid  = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) step();
      if (c == 1) if3.req_valid = 1'b0;
      tests++; if (if3.MemWrite !== (c == 4)) begin fails++; $display("FAIL store_memwrite c%0d: got %b want %b", c, if3.MemWrite, c == 4); end
      tests++; if (if3.done !== (c == 5)) begin fails++; $display("FAIL store_done c%0d: got %b want %b", c, if3.done, c == 5); end
      tests++; if (if3.MemRead !== 1'b0) begin fails++; $display("FAIL store_memread c%0d: got %b want 0", c, if3.MemRead); end
      if (c == 4) begin
        tests++; if (if3.Address !== 32'h80) begin fails++; $display("FAIL store_addr: got %h want 80", if3.Address); end
        tests++; if (if3.Write_data !== 32'hDEADBEEF) begin fails++; $display("FAIL store_wdata: got %h want deadbeef", if3.Write_data); end
      end
    end
    tests++; if (mem3[8'h20] !== 32'hDEADBEEF) begin fails++; $display("FAIL store_mem: got %h want deadbeef", mem3[8'h20]); end
    if3.req_op    = OP_LOAD;
    if3.req_valid = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) step();
      if (c == 1) if3.req_valid = 1'b0;
      tests++; if (if3.MemRead !== (c == 4)) begin fails++; $display("FAIL load_memread c%0d: got %b want %b", c, if3.MemRead, c == 4); end
      tests++; if (if3.done !== (c == 5)) begin fails++; $display("FAIL load_done c%0d: got %b want %b", c, if3.done, c == 5); end
      if (c == 5) begin
        tests++; if (if3.mdr !== 32'hDEADBEEF) begin fails++; $display("FAIL load_mdr: got %h want deadbeef", if3.mdr); end
        tests++; if (if3.ir !== 32'h0) begin fails++; $display("FAIL load_ir: got %h want 0", if3.ir); end
      end
    end
  endtask

  task automatic test_abort();
    bd(1'b1, 8'h40, 32'h12345678);
    if3.req_op    = OP_LOAD;
    if3.alu_addr  = 32'h100;
    if3.req_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      if (c == 1) if3.req_valid = 1'b0;
      if (c == 3) if3.abort = 1'b0;
      tests++; if (if3.MemRead !== 1'b0) begin fails++; $display("FAIL abort_memread c%0d: got %b want 0", c, if3.MemRead); end
      tests++; if (if3.done !== 1'b0) begin fails++; $display("FAIL abort_done c%0d: got %b want 0", c, if3.done); end
      if (c == 2) begin
        tests++; if (if3.req_ready !== 1'b0) begin fails++; $display("FAIL abort_wait_ready: got %b want 0", if3.req_ready); end
        if3.abort = 1'b1;
      end
      if (c == 3) begin
        tests++; if (if3.req_ready !== 1'b1) begin fails++; $display("FAIL abort_idle: got %b want 1", if3.req_ready); end
      end
    end
    tests++; if (if3.mdr !== 32'hDEADBEEF) begin fails++; $display("FAIL abort_mdr: got %h want deadbeef", if3.mdr); end
  endtask

  task automatic test_back_to_back();
    if0.req_op    = OP_RSVD;
    if0.alu_addr  = 32'h40;
    if0.req_valid = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) step();
      tests++; if (if0.req_ready !== (c % 3 == 0)) begin fails++; $display("FAIL b2b_ready c%0d: got %b want %b", c, if0.req_ready, c % 3 == 0); end
      tests++; if (if0.done !== (c % 3 == 2)) begin fails++; $display("FAIL b2b_done c%0d: got %b want %b", c, if0.done, c % 3 == 2); end
      tests++; if (if0.MemRead !== (c % 3 == 1)) begin fails++; $display("FAIL b2b_memread c%0d: got %b want %b", c, if0.MemRead, c % 3 == 1); end
    end
    if0.req_valid = 1'b0;
    tests++; if (if0.mdr !== 32'h11111111) begin fails++; $display("FAIL b2b_rsvd_mdr: got %h want 11111111", if0.mdr); end
    tests++; if (if0.ir !== 32'h20040005) begin fails++; $display("FAIL b2b_ir_hold: got %h want 20040005", if0.ir); end
  endtask

  task automatic test_reset_in_access();
    if3.req_op     = OP_STORE;
    if3.alu_addr   = 32'h80;
    if3.store_data = 32'hCAFEF00D;
    if3.req_valid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step();
      if (c == 1) if3.req_valid = 1'b0;
    end
    tests++; if (if3.MemWrite !== 1'b1) begin fails++; $display("FAIL rst_pre_memwrite: got %b want 1", if3.MemWrite); end
    reset = 1'b1;
    #1;
    tests++; if (if3.MemWrite !== 1'b0) begin fails++; $display("FAIL rst_memwrite: got %b want 0", if3.MemWrite); end
    step();
    reset = 1'b0;
    tests++; if (if3.req_ready !== 1'b1) begin fails++; $display("FAIL rst_idle: got %b want 1", if3.req_ready); end
    tests++; if (if3.done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", if3.done); end
    tests++; if (if3.mdr !== 32'h0) begin fails++; $display("FAIL rst_mdr: got %h want 0", if3.mdr); end
    tests++; if (if3.ir !== 32'h0) begin fails++; $display("FAIL rst_ir: got %h want 0", if3.ir); end
    tests++; if (mem3[8'h20] !== 32'hDEADBEEF) begin fails++; $display("FAIL rst_mem: got %h want deadbeef", mem3[8'h20]); end
  endtask

  task automatic test_misalign();
    bd(1'b0, 8'h20, 32'hA5A5A5A5);
    if0.req_op    = OP_LOAD;
    if0.alu_addr  = 32'h82;
    if0.req_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) step();
      if (c == 1) if0.req_valid = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      tests++; if (if0.MemRead !== 1'b0) begin fails++; $display("FAIL mis_memread c%0d: got %b want 0", c, if0.MemRead); end
      tests++; if (if0.done !== (c == 1)) begin fails++; $display("FAIL mis_done c%0d: got %b want %b", c, if0.done, c == 1); end
      tests++; if (if0.err !== (c == 1)) begin fails++; $display("FAIL mis_err c%0d: got %b want %b", c, if0.err, c == 1); end
`else
      tests++; if (if0.MemRead !== (c == 1)) begin fails++; $display("FAIL mis_memread c%0d: got %b want %b", c, if0.MemRead, c == 1); end
      tests++; if (if0.done !== (c == 2)) begin fails++; $display("FAIL mis_done c%0d: got %b want %b", c, if0.done, c == 2); end
      tests++; if (if0.err !== 1'b0) begin fails++; $display("FAIL mis_err c%0d: got %b want 0", c, if0.err); end
      if (c == 1) begin
        tests++; if (if0.Address !== 32'h82) begin fails++; $display("FAIL mis_addr: got %h want 82", if0.Address); end
      end
`endif
    end
`ifdef MEM_MISALIGN_TRAP_EN
    tests++; if (if0.mdr !== 32'h0) begin fails++; $display("FAIL mis_mdr: got %h want 0", if0.mdr); end
`else
    tests++; if (if0.mdr !== 32'hA5A5A5A5) begin fails++; $display("FAIL mis_mdr: got %h want a5a5a5a5", if0.mdr); end
`endif
  endtask

  initial begin
    if0.req_valid = 1'b0; if0.req_op = OP_FETCH; if0.pc = '0; if0.alu_addr = '0; if0.store_data = '0; if0.abort = 1'b0;
    if3.req_valid = 1'b0; if3.req_op = OP_FETCH; if3.pc = '0; if3.alu_addr = '0; if3.store_data = '0; if3.abort = 1'b0;
    test_reset();
    test_fetch();
    test_store_load();
    test_abort();
    test_back_to_back();
    test_reset_in_access();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
